// File: rtl/spi_slave_if_if.sv
// Bundle of the SPI pin signals and the core-side byte handshake of spi_slave_if.
// The slave modport is the front end's view; the master modport is the view of
// whatever drives the pins and plays the core.
interface spi_slave_if_if;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  logic       miso;
  logic       miso_oe;
  logic [7:0] rx_data;
  logic       data_rdy;
  logic [7:0] tx_data;
  logic       data_latch;
  logic       busy;

  modport slave (
    input  sclk, mosi, cs_n, tx_data, data_latch,
    output miso, miso_oe, rx_data, data_rdy, busy
  );

  modport master (
    output sclk, mosi, cs_n, tx_data, data_latch,
    input  miso, miso_oe, rx_data, data_rdy, busy
  );
endinterface

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front end. Oversamples SCLK/MOSI/CS_N in the sys_clk domain,
// deserialises MSB-first bytes to the core and serialises the byte the core hands
// over onto MISO.
// Optional feature: define SPI_LOOPBACK_EN to echo the last received byte whenever
// no transmit byte is pending (board bring-up aid); otherwise IDLE_BYTE is sent.
module spi_slave_if #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'h00
) (
  input logic          sys_clk,
  input logic          rst,
  spi_slave_if_if.slave bus
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclkSync_q, mosiSync_q, csnSync_q;
  logic                   sclkPrev_q, csnPrev_q;
  logic                   sclkS, mosiS, csnS;
  logic                   sclkRise, sclkFall, csFall, csRise;
  logic [7:0]             rxShift_q, rxData_q, txShift_q, txBuf_q;
  logic                   txValid_q, dataRdy_q, miso_q;
  logic [2:0]             bitCnt_q;
  logic [7:0]             rxComplete, fallbackByte, loadByte;
  logic                   byteDone, loadTx;

  assign sclkS = sclkSync_q[SYNC_STAGES-1];
  assign mosiS = mosiSync_q[SYNC_STAGES-1];
  assign csnS  = csnSync_q[SYNC_STAGES-1];

  assign sclkRise = sclkS & ~sclkPrev_q;
  assign sclkFall = ~sclkS & sclkPrev_q;
  assign csFall   = ~csnS & csnPrev_q;
  assign csRise   = csnS & ~csnPrev_q;

  // The byte being completed on this rise, including the freshly sampled MOSI bit
  assign rxComplete = {rxShift_q[6:0], mosiS};

  // cs_rise takes priority, so a coincident 8th rise does not complete the byte
  assign byteDone = (state_q == ACTIVE) && !csRise && sclkRise && (bitCnt_q == 3'd7);
  assign loadTx   = ((state_q == IDLE) && csFall) || byteDone;

`ifdef SPI_LOOPBACK_EN
  assign fallbackByte = byteDone ? rxComplete : rxData_q;
`else
  assign fallbackByte = IDLE_BYTE;
`endif

  // A latch in the same cycle as a load bypasses the buffer straight into the shifter
  assign loadByte = bus.data_latch ? bus.tx_data :
                    (txValid_q ? txBuf_q : fallbackByte);

  // Synchronise the asynchronous pins and keep one previous sample for edge detection
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sclkSync_q <= '0;
      mosiSync_q <= '0;
      csnSync_q  <= '1;
      sclkPrev_q <= 1'b0;
      csnPrev_q  <= 1'b1;
    end else begin
      sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], bus.sclk};
      mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], bus.mosi};
      csnSync_q  <= {csnSync_q[SYNC_STAGES-2:0], bus.cs_n};
      sclkPrev_q <= sclkS;
      csnPrev_q  <= csnS;
    end
  end

  // Frame state register
  always_ff @(posedge sys_clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Frame tracking: chip select edges move between IDLE and ACTIVE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (csFall) state_d = ACTIVE;
      ACTIVE:  if (csRise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift registers, bit counter and the transmit buffer handshake
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rxShift_q <= '0;
      rxData_q  <= '0;
      txShift_q <= '0;
      txBuf_q   <= '0;
      txValid_q <= 1'b0;
      dataRdy_q <= 1'b0;
      miso_q    <= 1'b0;
      bitCnt_q  <= '0;
    end else begin
      dataRdy_q <= 1'b0;
      miso_q    <= txShift_q[7];
      if (bus.data_latch) begin
        txBuf_q   <= bus.tx_data;
        txValid_q <= 1'b1;
      end
      if (loadTx) begin
        txShift_q <= loadByte;
        txValid_q <= 1'b0;
      end
      if (state_q == IDLE) begin
        if (csFall) bitCnt_q <= '0;
      end else if (csRise) begin
        bitCnt_q <= '0;
      end else if (sclkRise) begin
        rxShift_q <= rxComplete;
        bitCnt_q  <= bitCnt_q + 3'd1;
        if (bitCnt_q == 3'd7) begin
          rxData_q  <= rxComplete;
          dataRdy_q <= 1'b1;
        end
      end else if (sclkFall && (bitCnt_q != 3'd0)) begin
        txShift_q <= {txShift_q[6:0], 1'b0};
      end
    end
  end

  // Drive the outputs from registered state
  always_comb begin
    bus.busy     = (state_q == ACTIVE);
    bus.miso_oe  = (state_q == ACTIVE);
    bus.miso     = miso_q;
    bus.rx_data  = rxData_q;
    bus.data_rdy = dataRdy_q;
  end

endmodule
